boolean_decoder: RTL
====================

// Module: boolean_decoder
// PURPOSE
//   Inverse of the boolean unit. The boolean unit encodes a 4-bit alufn truth table into a function.
//   This block drives the four operand combinations into a boolean unit, samples its output,
//   and reconstructs the 4-bit alufn code that unit is executing.
//   Used as an FPGA self-test / op-identification engine beside the ALU.
// PARAMETERS
//   WIDTH   3   operand/result width of the attached boolean unit (>=1)
//   SETTLE  1   cycles each operand pair is held before the result is sampled (>=1)
// PORTS
//   clk        in   1      system clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   start      in   1      request a decode; sampled only in IDLE
//   bu_result  in   WIDTH  output of the attached boolean unit
//   bu_a       out  WIDTH  operand a driven to the boolean unit
//   bu_b       out  WIDTH  operand b driven to the boolean unit
//   busy       out  1      high from the start-capturing edge until done is asserted
//   done       out  1      one-cycle pulse: alufn_out and err are valid
//   alufn_out  out  4      decoded truth table, bit index {a,b} (AND=1000, XOR=0110, OR=1110)
//   err        out  1      some sample had non-uniform result bits
// BEHAVIOUR
//   Reset values:
//   - All outputs 0; FSM in IDLE; idx=0; settle counter=0.
//   - rst_n low mid-decode aborts immediately to this state. No done pulse is produced.
//   States:
//   - IDLE: bu_a=bu_b=0. On start=1, the next edge enters DRIVE with idx=0,
//     clears the working code and the working err, and sets busy=1.
//   - DRIVE: bu_a={WIDTH{idx[1]}}, bu_b={WIDTH{idx[0]}}. idx order is 0,1,2,3 (ab=00,01,10,11).
//     Each idx is held for exactly SETTLE cycles.
//     The edge ending the SETTLE-th cycle samples bu_result:
//     - working_code[idx] <= bu_result[0].
//     - If bu_result is neither all-0 nor all-1, working_err <= 1 (sticky for this run).
//     - On that same edge, idx increments, or the FSM moves to DONE when idx==3.
//   - DONE: one cycle; done=1, busy=0, bu_a=bu_b=0.
//     alufn_out and err are loaded on the edge entering DONE. The next edge returns to IDLE.
//   Timing and output hold:
//   - Latency: done is high in the cycle that begins 4*SETTLE edges after the start-capturing edge.
//   - alufn_out and err hold their values until the next DONE or reset.
//     They are not cleared by a new start.
//   Boundary conditions:
//   - start while busy or in DONE: ignored, not queued.
//   - start held high continuously: a new decode begins at the first IDLE cycle.
//     Back-to-back runs are spaced by exactly one IDLE cycle.
//   - WIDTH=1: err can never set.
//   - SETTLE=1: each combo is held for one cycle.
//   - Settle counter width is clog2(SETTLE)+1. It wraps to 0 on each idx advance.
//   - bu_result is treated as combinational-or-registered; it is not checked for X.
// TESTING
//   Bench instantiates boolean_unit #(WIDTH=3) fed by bu_a/bu_b/bu_result.
//   1. BU alufn_sig=1000, pulse start -> done after 4 cycles (SETTLE=1), alufn_out=1000, err=0.
//   2. alufn_sig=0110, then 1110 -> alufn_out=0110 then 1110, err=0, busy low in between.
//   3. Fault model: force bu_result[2]=1 while the other bits are 0 at ab=00 -> err=1, alufn_out[0]=0.
//   4. start re-pulsed at cycle 2 of a run, SETTLE=2 -> single done at 8 cycles, no second run.
//   5. rst_n low at cycle 3 of a run -> all outputs 0 immediately, no done.
//      The next start gives a correct result.
//   6. alufn_sig=0000 and 1111 -> alufn_out 0000 / 1111, err=0.

Source files
------------

// File: rtl/boolean_decoder_if.sv
// Bundles the decoder's control handshake and the operand/result bus of the attached boolean unit.
// The master modport is the decoder side; the slave modport is the requester/boolean-unit side.
interface boolean_decoder_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic             busy;
  logic             done;
  logic [3:0]       alufn_out;
  logic             err;
  logic [WIDTH-1:0] bu_a;
  logic [WIDTH-1:0] bu_b;
  logic [WIDTH-1:0] bu_result;

  modport master (
    input  start,
    input  bu_result,
    output busy,
    output done,
    output alufn_out,
    output err,
    output bu_a,
    output bu_b
  );

  modport slave (
    output start,
    output bu_result,
    input  busy,
    input  done,
    input  alufn_out,
    input  err,
    input  bu_a,
    input  bu_b
  );
endinterface

// File: rtl/boolean_decoder.sv
// Purpose: walks ab=00,01,10,11 through a boolean unit and rebuilds its 4-bit alufn truth table.
// Latency: done pulses in the cycle beginning 4*SETTLE edges after the start-capturing edge.
// Backpressure: none; start is only honoured in IDLE and is dropped (not queued) while busy or in DONE.
module boolean_decoder #(
  parameter int WIDTH  = 3,
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  boolean_decoder_if.master   bd
);

  localparam int              CW   = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0]   LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state;
  logic [1:0]    idx;
  logic [CW-1:0] settle_cnt;
  logic [3:0]    work_code;
  logic          work_err;

  logic [3:0]    code_next;
  logic [1:0]    idx_next;
  logic          mixed;

  // A sample is faulty when the result lanes disagree; with WIDTH=1 they never can.
  always_comb begin
    mixed          = !((&bd.bu_result) || !(|bd.bu_result));
    code_next      = work_code;
    code_next[idx] = bd.bu_result[0];
    idx_next       = idx + 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= 2'd0;
      settle_cnt   <= '0;
      work_code    <= 4'd0;
      work_err     <= 1'b0;
      bd.bu_a      <= '0;
      bd.bu_b      <= '0;
      bd.busy      <= 1'b0;
      bd.done      <= 1'b0;
      bd.alufn_out <= 4'd0;
      bd.err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bd.done <= 1'b0;
          if (bd.start) begin
            state      <= DRIVE;
            idx        <= 2'd0;
            settle_cnt <= '0;
            work_code  <= 4'd0;
            work_err   <= 1'b0;
            bd.bu_a    <= '0;
            bd.bu_b    <= '0;
            bd.busy    <= 1'b1;
          end
        end

        DRIVE: begin
          if (settle_cnt == LAST) begin
            settle_cnt <= '0;
            work_code  <= code_next;
            work_err   <= work_err | mixed;
            if (idx == 2'd3) begin
              // Results are published on the edge entering DONE and held until the next DONE.
              state        <= DONE;
              bd.done      <= 1'b1;
              bd.busy      <= 1'b0;
              bd.bu_a      <= '0;
              bd.bu_b      <= '0;
              bd.alufn_out <= code_next;
              bd.err       <= work_err | mixed;
            end else begin
              idx     <= idx_next;
              bd.bu_a <= {WIDTH{idx_next[1]}};
              bd.bu_b <= {WIDTH{idx_next[0]}};
            end
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        DONE: begin
          state   <= IDLE;
          bd.done <= 1'b0;
          idx     <= 2'd0;
        end

        default: begin
          state   <= IDLE;
          bd.done <= 1'b0;
          bd.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
